board_render_seq: RTL and testbench

//  Upstream sequencer for the per-tile square/number drawer on the 4x4 game board.

---
 rtl/render_pkg.sv | 27 ++
 rtl/render_watchdog.sv | 33 +++
 rtl/board_render_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_board_render_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the 4x4 board render sequencer.
package render_pkg;

    localparam int NUM_TILES = 16;
    localparam int TILE_W    = 4;
    localparam int IDX_W     = 4;
    localparam int WD_W      = 16;

    typedef logic [TILE_W-1:0]    tile_t;
    typedef tile_t [NUM_TILES-1:0] board_t;   // tile i occupies bits [4i+3:4i]
    typedef logic [IDX_W-1:0]     idx_t;

    localparam idx_t LAST_TILE = idx_t'(NUM_TILES - 1);

    typedef enum logic [3:0] {
        IDLE,
        LATCH,
        CHECK,
        ERASE_ISSUE,
        ERASE_WAIT,
        DRAW_ISSUE,
        DRAW_WAIT,
        NEXT,
        DONE
    } rstate_e;

endpackage

// File: rtl/render_watchdog.sv
// Loadable, saturating down-counter that flags a drawer that never answers.
// Loaded on the issue cycle, it counts once per wait cycle; expired is raised on
// the TIMEOUT_CYCLES-th consecutive wait cycle.
module render_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);
    import render_pkg::*;

    // First wait cycle already sees the reloaded value, so reload one short.
    localparam logic [WD_W-1:0] RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count_q;

    // Reload on issue, then count down while waiting; hold at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (count_en && (count_q != '0)) begin
            count_q <= count_q - WD_W'(1);
        end
    end

    assign expired = count_en && (count_q == '0);

endmodule

// File: rtl/board_render_seq.sv
// Board render sequencer: snapshots the 4x4 board and walks tiles 0..15, issuing an
// erase pass (old value, black) then a draw pass (new value, white) per refreshed
// tile through a start/done handshake with the square drawer.
module board_render_seq #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] board,
    input  logic        redraw_req,
    input  logic        update_req,
    input  logic        sq_done,
    output logic        sq_start,
    output logic [3:0]  sq_index,
    output logic [3:0]  sq_value,
    output logic        pixel_color,
    output logic        busy,
    output logic        frame_done,
    output logic        draw_error
);
    import render_pkg::*;

    rstate_e state_q, state_d;

    idx_t   tile_q;
    board_t snap_q;
    board_t shadow_q;
    logic   shadow_valid_q;
    logic   full_q;
    logic   pend_full_q;
    logic   pend_upd_q;
    logic   draw_error_q;
    tile_t  sq_value_q;
    logic   color_q;

    logic any_req;
    logic refresh;
    logic wd_expired;

    // Strobes from the FSM to the datapath registers.
    logic accept;
    logic accept_full;
    logic load_erase;
    logic load_draw;
    logic commit;
    logic tile_inc;
    logic frame_end;
    logic timeout;
    logic wd_load;
    logic wd_en;

    assign any_req = redraw_req | update_req;
    assign refresh = full_q || (snap_q[tile_q] != shadow_q[tile_q]);

    render_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .count_en (wd_en),
        .expired  (wd_expired)
    );

    // State register; reset aborts any frame in flight and drops sq_start at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the strobes that steer the datapath.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        accept      = 1'b0;
        accept_full = 1'b0;
        load_erase  = 1'b0;
        load_draw   = 1'b0;
        commit      = 1'b0;
        tile_inc    = 1'b0;
        frame_end   = 1'b0;
        timeout     = 1'b0;
        wd_load     = 1'b0;
        wd_en       = 1'b0;
        sq_start    = 1'b0;
        frame_done  = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = LATCH;
                    accept      = 1'b1;
                    accept_full = redraw_req | ~shadow_valid_q;
                end
            end
            LATCH: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (refresh) begin
                    if (shadow_valid_q) begin
                        state_d    = ERASE_ISSUE;
                        load_erase = 1'b1;
                    end else begin
                        state_d   = DRAW_ISSUE;
                        load_draw = 1'b1;
                    end
                end else begin
                    state_d = NEXT;
                end
            end
            ERASE_ISSUE: begin
                sq_start = 1'b1;
                wd_load  = 1'b1;
                state_d  = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                wd_en = 1'b1;
                if (sq_done) begin
                    state_d   = DRAW_ISSUE;
                    load_draw = 1'b1;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            DRAW_ISSUE: begin
                sq_start = 1'b1;
                wd_load  = 1'b1;
                state_d  = DRAW_WAIT;
            end
            DRAW_WAIT: begin
                wd_en = 1'b1;
                if (sq_done) begin
                    state_d = NEXT;
                    commit  = 1'b1;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            NEXT: begin
                if (tile_q == LAST_TILE) begin
                    state_d = DONE;
                end else begin
                    state_d  = CHECK;
                    tile_inc = 1'b1;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                frame_end  = 1'b1;
                // A queued (or same-cycle) request chains straight into the next frame.
                // The shadow becomes valid on this edge, so only an explicit redraw forces full mode.
                if (pend_full_q || pend_upd_q || any_req) begin
                    state_d     = LATCH;
                    accept      = 1'b1;
                    accept_full = pend_full_q | redraw_req;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tile counter: advances only from NEXT, so it never wraps past the last tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tile_q <= '0;
        end else if (frame_end || timeout) begin
            tile_q <= '0;
        end else if (tile_inc) begin
            tile_q <= tile_q + idx_t'(1);
        end
    end

    // Snapshot and mode are captured once per frame so mid-frame board edits cannot tear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
            full_q <= 1'b0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            snap_q <= board_t'(board);
            full_q <= accept_full;
        end
    end

    // Shadow of what is on screen: a tile is committed only after its draw pass completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shadow is reset explicitly; a mid-frame reset leaves the screen unknown, and a
            //       cleared shadow plus shadow_valid=0 guarantees the next frame repaints everything.
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            if (commit) begin
                shadow_q[tile_q] <= snap_q[tile_q];
            end
            if (frame_end) begin
                shadow_valid_q <= 1'b1;
            end else if (timeout) begin
                shadow_valid_q <= 1'b0;
            end
        end
    end

    // One-deep pending request flags; a pending full redraw dominates a pending update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_full_q <= 1'b0;
            pend_upd_q  <= 1'b0;
        end else if (accept || timeout) begin
            pend_full_q <= 1'b0;
            pend_upd_q  <= 1'b0;
        end else if (busy) begin
            if (redraw_req) begin
                pend_full_q <= 1'b1;
            end
            if (update_req) begin
                pend_upd_q <= 1'b1;
            end
        end
    end

    // Sticky error flag: set by a drawer timeout, cleared when the next request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            draw_error_q <= 1'b0;
        end else if (timeout) begin
            draw_error_q <= 1'b1;
        end else if (accept) begin
            draw_error_q <= 1'b0;
        end
    end

    // Pass value and colour are loaded when a pass is chosen and held until the next pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_value_q <= '0;
            color_q    <= 1'b0;
        end else if (load_erase) begin
            sq_value_q <= shadow_q[tile_q];
            color_q    <= 1'b0;
        end else if (load_draw) begin
            sq_value_q <= snap_q[tile_q];
            color_q    <= 1'b1;
        end
    end

    assign sq_index    = tile_q;
    assign sq_value    = sq_value_q;
    assign pixel_color = color_q;
    assign draw_error  = draw_error_q;

endmodule

// File: tb/tb_board_render_seq.sv
// Scoreboard bench for board_render_seq: a frame-level model predicts the ordered list
// of drawer commands and frame_done events; a monitor compares what the DUT presents.
module tb_board_render_seq;

    localparam int TIMEOUT      = 16;
    localparam int FRAME_BUDGET = 2000;
    localparam logic [9:0] FRAME_EV = 10'h200;

    logic        clk;
    logic        reset;
    logic [63:0] board;
    logic        redraw_req;
    logic        update_req;
    logic        sq_done;
    logic        sq_start;
    logic [3:0]  sq_index;
    logic [3:0]  sq_value;
    logic        pixel_color;
    logic        busy;
    logic        frame_done;
    logic        draw_error;

    int checks_total  = 0;
    int checks_passed = 0;

    // Expected events: {kind(1=frame_done), index, value, color}
    logic [9:0]  exp_q[$];
    logic [9:0]  last_ev;

    // Reference model of what is on screen
    logic [63:0] m_shadow;
    bit          m_valid;

    // Drawer model controls
    int dcnt;
    int drawer_fixed;
    bit stall;

    board_render_seq #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .board       (board),
        .redraw_req  (redraw_req),
        .update_req  (update_req),
        .sq_done     (sq_done),
        .sq_start    (sq_start),
        .sq_index    (sq_index),
        .sq_value    (sq_value),
        .pixel_color (pixel_color),
        .busy        (busy),
        .frame_done  (frame_done),
        .draw_error  (draw_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: which tiles change, what gets erased and drawn, in tile order.
    function automatic void model_frame(input bit full, input bit stall_first);
        logic [9:0] evs[$];
        logic [3:0] nv;
        logic [3:0] ov;
        for (int i = 0; i < 16; i++) begin
            nv = board[4*i +: 4];
            ov = m_shadow[4*i +: 4];
            if (full || nv != ov) begin
                if (m_valid) evs.push_back({1'b0, 4'(i), ov, 1'b0});
                evs.push_back({1'b0, 4'(i), nv, 1'b1});
            end
        end
        if (stall_first) begin
            // The drawer never answers: only the first command appears, nothing commits.
            if (evs.size() > 0) exp_q.push_back(evs[0]);
            m_valid = 1'b0;
        end else begin
            foreach (evs[k]) exp_q.push_back(evs[k]);
            exp_q.push_back(FRAME_EV);
            m_shadow = board;
            m_valid  = 1'b1;
        end
    endfunction

    // Drawer model: sq_done pulses N cycles after each sq_start (never while stalled).
    initial begin
        sq_done = 1'b0;
        dcnt    = 0;
        forever begin
            @(negedge clk);
            if (reset && sq_start && !stall)
                dcnt = (drawer_fixed > 0) ? drawer_fixed : int'($urandom_range(1, 6));
            @(posedge clk);
            #2;
            sq_done = 1'b0;
            if (!reset) dcnt = 0;
            else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) sq_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command or frame_done.
    initial begin
        logic [9:0] act;
        last_ev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (sq_start || frame_done) begin
                    act = sq_start ? {1'b0, sq_index, sq_value, pixel_color} : FRAME_EV;
                    if (exp_q.size() == 0) check("unexpected_event", 32'(act), 32'h3FF);
                    else check("event", 32'(act), 32'(exp_q.pop_front()));
                    if (sq_start) last_ev = act;
                end
                if (sq_done && busy)
                    check("held_until_done", {sq_index, sq_value, pixel_color}, last_ev[8:0]);
            end
        end
    end

    // Wait for frame_done, checking busy never drops; optionally inject a redraw mid-frame.
    task automatic wait_frame(input int inject_at, output int lat);
        bit seen;
        bit dropped;
        lat = 0;
        seen = 0;
        dropped = 0;
        while (!seen && lat < FRAME_BUDGET) begin
            @(posedge clk);
            #1;
            redraw_req = 1'b0;
            update_req = 1'b0;
            if (inject_at > 0 && lat == inject_at) begin
                redraw_req = 1'b1;
                model_frame(1'b1, 1'b0);
            end
            @(negedge clk);
            lat++;
            if (frame_done) seen = 1;
            else if (!busy) dropped = 1;
        end
        check("frame_done_seen", 32'(seen), 1);
        check("busy_held", 32'(dropped), 0);
        check("draw_error_clear", 32'(draw_error), 0);
    endtask

    task automatic run_frame(input logic rd, input logic up, input int inject_at, output int lat);
        @(posedge clk);
        #1;
        redraw_req = rd;
        update_req = up;
        model_frame(rd | !m_valid, 1'b0);
        @(negedge clk);
        check("busy_low_on_request", 32'(busy), 0);
        wait_frame(inject_at, lat);
    endtask

    initial begin
        int  lat;
        int  cyc_after;
        bit  seen_start;
        bit  done_seen;
        bit  found;
        int  nchg;
        int  t;

        reset        = 1'b0;
        board        = '0;
        redraw_req   = 1'b0;
        update_req   = 1'b0;
        stall        = 1'b0;
        drawer_fixed = 5;
        m_shadow     = '0;
        m_valid      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {sq_start, busy, frame_done, draw_error, pixel_color, sq_index, sq_value}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: first update after reset is a full draw, no erases
        board = {16{4'h2}};
        run_frame(1'b0, 1'b1, 0, lat);

        // 2: single changed tile -> one erase + one draw
        board[23:20] = 4'h4;
        run_frame(1'b0, 1'b1, 0, lat);

        // 3: no changes -> frame_done 34 cycles after the request
        run_frame(1'b0, 1'b1, 0, lat);
        check("nochange_latency", 32'(lat), 34);

        // 4: both requests together, redraw again mid-frame -> back-to-back full frames
        drawer_fixed = 0;
        run_frame(1'b1, 1'b1, 20, lat);
        wait_frame(0, lat);

        // Randomized update frames and one plain redraw
        for (int it = 0; it < 4; it++) begin
            nchg = int'($urandom_range(1, 3));
            for (int c = 0; c < nchg; c++) begin
                t = int'($urandom_range(0, 15));
                board[4*t +: 4] = 4'($urandom);
            end
            run_frame(1'b0, 1'b1, 0, lat);
        end
        board = {$urandom, $urandom};
        run_frame(1'b1, 1'b0, 0, lat);

        // 5: drawer stalls -> timeout after TIMEOUT wait cycles
        stall = 1'b1;
        board[15:12] = board[15:12] + 4'h1;
        @(posedge clk);
        #1;
        update_req = 1'b1;
        model_frame(!m_valid, 1'b1);
        @(posedge clk);
        #1;
        update_req = 1'b0;
        seen_start = 0;
        done_seen  = 0;
        cyc_after  = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (frame_done) done_seen = 1;
            if (sq_start) begin
                seen_start = 1;
                cyc_after  = 0;
            end else if (seen_start) cyc_after++;
            if (seen_start && !busy) break;
        end
        check("timeout_cycles", 32'(cyc_after), TIMEOUT + 1);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_error", 32'(draw_error), 1);
        check("timeout_no_frame_done", 32'(done_seen), 0);
        repeat (3) @(negedge clk);
        check("error_sticky", 32'(draw_error), 1);
        stall = 1'b0;
        run_frame(1'b0, 1'b1, 0, lat);

        // 6: reset during DRAW_WAIT of tile 7
        board = {$urandom, $urandom};
        @(posedge clk);
        #1;
        redraw_req = 1'b1;
        model_frame(1'b1, 1'b0);
        @(posedge clk);
        #1;
        redraw_req = 1'b0;
        found = 0;
        for (int k = 0; k < FRAME_BUDGET && !found; k++) begin
            @(negedge clk);
            if (sq_start && sq_index == 4'd7 && pixel_color) found = 1;
        end
        check("tile7_draw_reached", 32'(found), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_shadow = '0;
        m_valid  = 1'b0;
        #1;
        check("reset_mid_frame_outputs",
              {sq_start, busy, frame_done, draw_error, pixel_color, sq_index, sq_value}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_frame(1'b0, 1'b1, 0, lat);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
